sa_seq: RTL
===========

Name: sa_seq

Overview:
Sequencer for one fp16 MAC systolic-array tile. Per job it clears the PE accumulators, then streams K operand beats with per-row and per-column skew. It waits for the array and the product normalisation pipeline to flush, then drains results one row at a time under backpressure. It sits between the tile's operand buffers and the PE grid; it has no datapath of its own.

Parameters:
ROWS, 4, PE rows; row-skew depth and drain beat count.
COLS, 4, PE columns; column-skew depth.
KW, 8, width of K_LEN and K_IDX.
PIPE_LAT, 1, per-PE multiply/normalise/accumulate latency in cycles; 1 with the normaliser output register disabled, 2 with it enabled.

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
START  in  1  job request, sampled in IDLE only
K_LEN  in  KW  reduction length, captured when START is accepted
BUSY  out  1  high in every non-IDLE state
ERR  out  1  1-cycle pulse: START with K_LEN==0
ACC_CLR  out  1  1-cycle accumulator clear to all PEs
FEED_EN  out  1  operand beat valid (unskewed)
K_IDX  out  KW  operand index of the current beat
ROW_EN  out  ROWS  ROW_EN[r] = FEED_EN delayed r cycles
COL_EN  out  COLS  COL_EN[c] = FEED_EN delayed c cycles
DRAIN_VALID  out  1  result row valid
DRAIN_ROW  out  $clog2(ROWS)  row being drained
DRAIN_READY  in  1  consumer accepts the drain beat
DONE  out  1  1-cycle job-complete pulse

Behaviour:
- Reset (async, any state): state IDLE; all outputs, counters and skew shift registers 0. On release, first rising edge evaluates from IDLE.
- Outputs are decoded from registered state and counters (Moore). No input-to-output combinational path except none.
- FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, FIN.
- IDLE:
  - START=1 and K_LEN!=0: latch K_LEN, go to CLEAR.
  - START=1 and K_LEN==0: ERR=1 for the next cycle, stay IDLE.
- CLEAR: ACC_CLR=1 for exactly 1 cycle, then FEED.
- FEED:
  - Lasts exactly K_LEN cycles; FEED_EN=1; K_IDX counts 0..K_LEN-1.
  - After the last beat, go to FLUSH. No backpressure on feed.
  - K_LEN = 2^KW-1 is legal; the K_IDX counter never wraps within a job.
- ROW_EN[0]=COL_EN[0]=FEED_EN. Bits r,c>0 come from shift registers that keep shifting in FLUSH, so every row/column sees exactly K_LEN beats.
- FLUSH: lasts FLUSH_CYC = ROWS+COLS-2+PIPE_LAT cycles, counted by a down-counter, then DRAIN.
- DRAIN:
  - DRAIN_VALID=1; DRAIN_ROW starts at 0.
  - Beat completes on a cycle with DRAIN_VALID & DRAIN_READY; DRAIN_ROW then increments.
  - DRAIN_READY low holds DRAIN_ROW and DRAIN_VALID stable.
  - After row ROWS-1 is accepted, go to FIN.
- FIN: DONE=1 for 1 cycle, BUSY still 1, then IDLE.
- START outside IDLE is ignored; no queueing. K_LEN changes after acceptance are ignored.
- START in the first IDLE cycle after FIN is accepted (back-to-back jobs, 1 idle cycle between).
- BUSY=0 only in IDLE.

Optional Feature:
Macro SA_SEQ_ABORT_EN.
- Defined:
  - Adds input ABORT and output ABORTED.
  - ABORT=1 in any non-IDLE state: next cycle state IDLE, skew registers and counters cleared, DONE not asserted, ABORTED=1 for 1 cycle.
  - ABORT in IDLE has no effect.
  - ABORT has priority over same-cycle FSM transitions, including FIN.
- Undefined: neither port exists; behaviour is as above.

Test Plan:
Unless stated, ROWS=COLS=4, PIPE_LAT=2, so FLUSH_CYC=8. Cycle 0 is the cycle in which START=1 is sampled.
1. Assert RST mid-cycle with no clock edge -> all outputs 0 immediately. Release, idle 5 cycles -> outputs stay 0.
2. START with K_LEN=3, DRAIN_READY=1 -> expected sequence:
   - BUSY cycles 1-17; ACC_CLR cycle 1.
   - FEED_EN cycles 2-4 with K_IDX 0,1,2; ROW_EN[3] and COL_EN[3] cycles 5-7.
   - DRAIN_VALID cycles 13-16 with DRAIN_ROW 0..3; DONE cycle 17; IDLE cycle 18.
3. Same job, DRAIN_READY=0 on cycles 14-15 -> DRAIN_ROW holds 1 on cycles 14-16; DONE on cycle 19.
4. START with K_LEN=0 -> ERR=1 on cycle 1; BUSY, ACC_CLR and FEED_EN stay 0.
5. START again during FEED -> ignored, beat count unchanged. RST asserted during FEED (K_IDX=1) -> all outputs 0 at once; no DONE. Next START runs a full job.
6. With SA_SEQ_ABORT_EN, ABORT during FLUSH -> next cycle BUSY=0, ABORTED=1, no DONE, no DRAIN_VALID. A following START with K_LEN=1 completes with DONE on cycle 15.

Source files
------------

// File: rtl/sa_seq.sv
// sa_seq: sequencer for one fp16 MAC systolic-array tile.
// For each job it clears the accumulators, then feeds K_LEN operand beats with
// row/column skew. It waits for the array pipeline to flush, then drains one
// result row per accepted beat. It has no datapath of its own.
// Optional build macro: SA_SEQ_ABORT_EN adds the ABORT input and ABORTED output.
module sa_seq #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int KW       = 8,
    parameter int PIPE_LAT = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [KW-1:0]           K_LEN,
`ifdef SA_SEQ_ABORT_EN
    input  logic                    ABORT,
    output logic                    ABORTED,
`endif
    output logic                    BUSY,
    output logic                    ERR,
    output logic                    ACC_CLR,
    output logic                    FEED_EN,
    output logic [KW-1:0]           K_IDX,
    output logic [ROWS-1:0]         ROW_EN,
    output logic [COLS-1:0]         COL_EN,
    output logic                    DRAIN_VALID,
    output logic [$clog2(ROWS)-1:0] DRAIN_ROW,
    input  logic                    DRAIN_READY,
    output logic                    DONE
);

    // The last skewed PE sees its final product after ROWS-1 + COLS-1 cycles of
    // skew plus the per-PE pipeline latency.
    localparam int FLUSH_CYC = ROWS + COLS - 2 + PIPE_LAT;
    localparam int FCW       = $clog2(FLUSH_CYC + 1);
    localparam int RW        = $clog2(ROWS);
    localparam int SKMAX     = ((ROWS > COLS) ? ROWS : COLS) - 1;
    localparam int SKW       = (SKMAX < 1) ? 1 : SKMAX;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [KW-1:0]  klen_q, klen_d;
    logic [KW-1:0]  kidx_q, kidx_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [RW-1:0]  row_q, row_d;
    logic           err_q, err_d;
    logic           aborted_q;
    logic [SKW-1:0] sh_q;
    logic           abort_w;

`ifdef SA_SEQ_ABORT_EN
    assign abort_w = ABORT && (state_q != S_IDLE);
    assign ABORTED = aborted_q;
`else
    assign abort_w = 1'b0;
`endif

    // Next-state and counter update; an abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        kidx_d  = kidx_q;
        fcnt_d  = fcnt_q;
        row_d   = row_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (K_LEN != '0) begin
                        klen_d  = K_LEN;
                        state_d = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                kidx_d  = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                // Compare against K_LEN-1 so K_LEN = 2^KW-1 never wraps K_IDX.
                if (kidx_q == klen_q - KW'(1)) begin
                    kidx_d  = '0;
                    fcnt_d  = FCW'(FLUSH_CYC - 1);
                    state_d = S_FLUSH;
                end else begin
                    kidx_d = kidx_q + KW'(1);
                end
            end
            S_FLUSH: begin
                if (fcnt_q == '0) begin
                    row_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end
            S_DRAIN: begin
                if (DRAIN_READY) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = S_FIN;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_w) begin
            state_d = S_IDLE;
            kidx_d  = '0;
            fcnt_d  = '0;
            row_d   = '0;
        end
    end

    // FSM state, counters and the one-cycle status pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            klen_q    <= '0;
            kidx_q    <= '0;
            fcnt_q    <= '0;
            row_q     <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            klen_q    <= klen_d;
            kidx_q    <= kidx_d;
            fcnt_q    <= fcnt_d;
            row_q     <= row_d;
            err_q     <= err_d;
            aborted_q <= abort_w;
        end
    end

    // Skew line: sh_q[i] is FEED_EN delayed i+1 cycles; it keeps shifting
    // through FLUSH so the far rows/columns still receive every beat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh_q <= '0;
        end else if (abort_w) begin
            sh_q <= '0;
        end else begin
            sh_q[0] <= FEED_EN;
            for (int i = 1; i < SKW; i++) begin
                sh_q[i] <= sh_q[i-1];
            end
        end
    end

    assign BUSY        = (state_q != S_IDLE);
    assign ERR         = err_q;
    assign ACC_CLR     = (state_q == S_CLEAR);
    assign FEED_EN     = (state_q == S_FEED);
    assign K_IDX       = kidx_q;
    assign DRAIN_VALID = (state_q == S_DRAIN);
    assign DRAIN_ROW   = row_q;
    assign DONE        = (state_q == S_FIN);

    assign ROW_EN[0] = FEED_EN;
    assign COL_EN[0] = FEED_EN;
    for (genvar r = 1; r < ROWS; r++) begin : g_row
        assign ROW_EN[r] = sh_q[r-1];
    end
    for (genvar c = 1; c < COLS; c++) begin : g_col
        assign COL_EN[c] = sh_q[c-1];
    end

endmodule
